dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 150 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory access controller for the M stage.
// Sub-word loads/stores over a word-wide synchronous RAM.
module dmem_ctrl (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  memop,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic [29:0] ram_addr,
    output logic        ram_rd,
    output logic        ram_wr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        we_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;
    logic        err_q;
    logic [31:0] word_q;
    logic        bad_in;
    logic        accept;
    logic [31:0] merged;
    logic [31:0] ext;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign accept = (state == IDLE) && req;

    // Flag illegal opcodes and misaligned H/W addresses at acceptance.
    always_comb begin
        bad_in = 1'b0;
        if (memop[1:0] == 2'b11 || memop == 3'b110)
            bad_in = 1'b1;
        else if (memop[1:0] == 2'b01 && addr[0])
            bad_in = 1'b1;
        else if (memop[1:0] == 2'b10 && addr[1:0] != 2'b00)
            bad_in = 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; word stores skip the read phase.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (bad_in)
                        state_nx = DONE;
                    else if (we && memop[1:0] == 2'b10)
                        state_nx = WR;
                    else
                        state_nx = RD;
                end
            end
            RD:      state_nx = CAP;
            CAP:     state_nx = we_q ? WR : DONE;
            WR:      state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded purely from state and latched request.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        ram_rd    = (state == RD);
        ram_wr    = (state == WR);
        err       = (state == DONE) && err_q;
        ram_addr  = (state == IDLE) ? 30'd0 : addr_q[31:2];
        ram_wdata = (state == IDLE) ? 32'd0 : word_q;
    end

    // Lane select and merge of store data into the read word.
    always_comb begin
        byte_sel = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        merged   = ram_rdata;
        if (op_q[0]) begin
            if (addr_q[1])
                merged[31:16] = wdata_q;
            else
                merged[15:0] = wdata_q;
        end else begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    // Load extension by memop.
    always_comb begin
        case (op_q)
            3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  ext = {24'd0, byte_sel};
            3'b101:  ext = {16'd0, half_sel};
            default: ext = ram_rdata;
        endcase
    end

    // Request latches, RMW word and load result register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            we_q    <= 1'b0;
            op_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 16'd0;
            err_q   <= 1'b0;
            word_q  <= 32'd0;
            rdata   <= 32'd0;
        end else if (accept) begin
            we_q    <= we;
            op_q    <= memop;
            addr_q  <= addr;
            wdata_q <= wdata[15:0];
            err_q   <= bad_in;
            word_q  <= wdata;
        end else if (state == CAP) begin
            if (we_q)
                word_q <= merged;
            else
                rdata <= ext;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a small synchronous RAM model.
// Each task drives one scenario and checks its own results.
module tb_dmem_ctrl;

    logic        clk;
    logic        clr_n;
    logic        req;
    logic        we;
    logic [2:0]  memop;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        err;
    logic [29:0] ram_addr;
    logic        ram_rd;
    logic        ram_wr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:255];
    logic        preload;
    int          rd_cnt;
    int          wr_cnt;
    logic [29:0] last_rd_addr;
    logic [29:0] last_wr_addr;
    logic [31:0] last_wdata;

    int n_cmp;
    int n_bad;

    dmem_ctrl dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req       (req),
        .we        (we),
        .memop     (memop),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .busy      (busy),
        .err       (err),
        .ram_addr  (ram_addr),
        .ram_rd    (ram_rd),
        .ram_wr    (ram_wr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: read data valid the cycle after ram_rd.
    always @(posedge clk) begin
        if (preload)
            mem[64] <= 32'h8899AABB;
        else if (ram_wr)
            mem[ram_addr[7:0]] <= ram_wdata;
        if (ram_rd)
            ram_rdata <= mem[ram_addr[7:0]];
    end

    // Strobe monitor.
    always @(posedge clk) begin
        if (ram_rd) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= ram_addr;
        end
        if (ram_wr) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= ram_addr;
            last_wdata   <= ram_wdata;
        end
    end

    // One access from IDLE; lat = cycle of done after the accepting edge.
    task automatic access(input logic w, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic e);
        lat = 0;
        e   = 1'b0;
        req   = 1'b1;
        we    = w;
        memop = op;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                e   = err;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_preload();
        @(posedge clk);
        #1 preload = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        #3;
        n_cmp++;
        if ({done, busy, err, ram_rd, ram_wr} !== 5'b0) begin
            $display("FAIL reset_ctrl got %b want 00000",
                     {done, busy, err, ram_rd, ram_wr});
            n_bad++;
        end
        n_cmp++;
        if (rdata !== 32'd0) begin
            $display("FAIL reset_rdata got %h want 0", rdata);
            n_bad++;
        end
        n_cmp++;
        if (ram_addr !== 30'd0 || ram_wdata !== 32'd0) begin
            $display("FAIL reset_ram got %h/%h want 0/0",
                     ram_addr, ram_wdata);
            n_bad++;
        end
        @(negedge clk);
        clr_n = 1'b1;
        do_preload();
    endtask

    task automatic test_lb();
        int lat;
        logic e;
        int r0;
        int w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        access(1'b0, 3'b000, 32'h103, 32'h0, lat, e);
        n_cmp++;
        if (lat !== 3) begin
            $display("FAIL lb_latency got %0d want 3", lat);
            n_bad++;
        end
        n_cmp++;
        if (rdata !== 32'hFFFFFF88 || e !== 1'b0) begin
            $display("FAIL lb_data got %h err %b want ffffff88 err 0",
                     rdata, e);
            n_bad++;
        end
        n_cmp++;
        if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 0) begin
            $display("FAIL lb_strobes got rd %0d wr %0d want 1 0",
                     rd_cnt - r0, wr_cnt - w0);
            n_bad++;
        end
        n_cmp++;
        if (last_rd_addr !== 30'h40) begin
            $display("FAIL lb_ram_addr got %h want 40", last_rd_addr);
            n_bad++;
        end
    endtask

    task automatic test_load_ext();
        int lat;
        logic e;
        access(1'b0, 3'b100, 32'h103, 32'h0, lat, e);
        n_cmp++;
        if (rdata !== 32'h00000088 || lat !== 3) begin
            $display("FAIL lbu got %h lat %0d want 00000088 lat 3",
                     rdata, lat);
            n_bad++;
        end
        access(1'b0, 3'b101, 32'h102, 32'h0, lat, e);
        n_cmp++;
        if (rdata !== 32'h00008899 || e !== 1'b0) begin
            $display("FAIL lhu got %h err %b want 00008899 err 0",
                     rdata, e);
            n_bad++;
        end
        access(1'b0, 3'b001, 32'h100, 32'h0, lat, e);
        n_cmp++;
        if (rdata !== 32'hFFFFAABB || e !== 1'b0) begin
            $display("FAIL lh got %h err %b want ffffaabb err 0",
                     rdata, e);
            n_bad++;
        end
    endtask

    task automatic test_store_byte();
        int lat;
        logic e;
        int r0;
        int w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        access(1'b1, 3'b000, 32'h101, 32'h12345677, lat, e);
        n_cmp++;
        if (lat !== 4 || e !== 1'b0) begin
            $display("FAIL sb_latency got %0d err %b want 4 err 0",
                     lat, e);
            n_bad++;
        end
        n_cmp++;
        if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 1) begin
            $display("FAIL sb_strobes got wr %0d rd %0d want 1 1",
                     wr_cnt - w0, rd_cnt - r0);
            n_bad++;
        end
        n_cmp++;
        if (last_wdata !== 32'h889977BB || last_wr_addr !== 30'h40) begin
            $display("FAIL sb_wdata got %h@%h want 889977bb@40",
                     last_wdata, last_wr_addr);
            n_bad++;
        end
        n_cmp++;
        if (rdata !== 32'hFFFFAABB) begin
            $display("FAIL sb_rdata got %h want ffffaabb", rdata);
            n_bad++;
        end
        do_preload();
    endtask

    task automatic test_illegal();
        int lat;
        logic e;
        int r0;
        int w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        access(1'b0, 3'b010, 32'h102, 32'h0, lat, e);
        n_cmp++;
        if (lat !== 1 || e !== 1'b1) begin
            $display("FAIL lw_misalign got lat %0d err %b want 1 1",
                     lat, e);
            n_bad++;
        end
        access(1'b0, 3'b110, 32'h100, 32'h0, lat, e);
        n_cmp++;
        if (lat !== 1 || e !== 1'b1) begin
            $display("FAIL bad_op got lat %0d err %b want 1 1", lat, e);
            n_bad++;
        end
        n_cmp++;
        if (rd_cnt - r0 !== 0 || wr_cnt - w0 !== 0) begin
            $display("FAIL illegal_strobes got rd %0d wr %0d want 0 0",
                     rd_cnt - r0, wr_cnt - w0);
            n_bad++;
        end
        n_cmp++;
        if (rdata !== 32'hFFFFAABB) begin
            $display("FAIL illegal_rdata got %h want ffffaabb", rdata);
            n_bad++;
        end
    endtask

    task automatic test_reset_mid_wr();
        int w0;
        int dn;
        w0 = wr_cnt;
        dn = 0;
        req   = 1'b1;
        we    = 1'b1;
        memop = 3'b010;
        addr  = 32'h100;
        wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 req = 1'b0;
        n_cmp++;
        if (ram_wr !== 1'b1 || ram_wdata !== 32'hDEADBEEF) begin
            $display("FAIL sw_wr_phase got wr %b data %h want 1 deadbeef",
                     ram_wr, ram_wdata);
            n_bad++;
        end
        #1 clr_n = 1'b0;
        #1;
        n_cmp++;
        if ({done, busy, err, ram_rd, ram_wr} !== 5'b0 ||
            ram_addr !== 30'd0 || ram_wdata !== 32'd0 ||
            rdata !== 32'd0) begin
            $display("FAIL rst_mid_wr got ctl %b addr %h wd %h rd %h want 0",
                     {done, busy, err, ram_rd, ram_wr},
                     ram_addr, ram_wdata, rdata);
            n_bad++;
        end
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (done)
                dn++;
        end
        n_cmp++;
        if (dn !== 0 || wr_cnt - w0 !== 0) begin
            $display("FAIL rst_no_done got done %0d wr %0d want 0 0",
                     dn, wr_cnt - w0);
            n_bad++;
        end
        n_cmp++;
        if (mem[64] !== 32'h8899AABB) begin
            $display("FAIL rst_ram got %h want 8899aabb", mem[64]);
            n_bad++;
        end
    endtask

    task automatic test_back_to_back();
        int d1;
        int d2;
        int idle;
        d1 = 0;
        d2 = 0;
        idle = 0;
        @(posedge clk);
        #1;
        req   = 1'b1;
        we    = 1'b0;
        memop = 3'b010;
        addr  = 32'h100;
        wdata = 32'h0;
        @(posedge clk);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 5)
                req = 1'b0;
            if (done) begin
                if (d1 == 0)
                    d1 = n;
                else if (d2 == 0)
                    d2 = n;
            end
            if (d1 != 0 && d2 == 0 && !busy)
                idle++;
        end
        n_cmp++;
        if (d1 !== 3 || d2 !== 7) begin
            $display("FAIL b2b_done got %0d,%0d want 3,7", d1, d2);
            n_bad++;
        end
        n_cmp++;
        if (idle !== 1) begin
            $display("FAIL b2b_idle got %0d want 1", idle);
            n_bad++;
        end
        n_cmp++;
        if (rdata !== 32'h8899AABB) begin
            $display("FAIL b2b_rdata got %h want 8899aabb", rdata);
            n_bad++;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rd_cnt = 0;
        wr_cnt = 0;
        last_rd_addr = '0;
        last_wr_addr = '0;
        last_wdata = '0;
        ram_rdata = '0;
        preload = 1'b0;
        clr_n = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        memop = 3'b000;
        addr  = 32'h0;
        wdata = 32'h0;
        #1;
        test_reset();
        test_lb();
        test_load_ext();
        test_store_byte();
        test_illegal();
        test_reset_mid_wr();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
